instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Instruction encoder and program loader; the producer end of the opcode/control decode path.
- Accepts decoded instruction fields over a valid/ready stream and assembles 32-bit MIPS words using the same opcode set the control unit decodes.
- Writes the words sequentially into instruction memory through a simple write port.
- Used at bring-up and in benches to load programs without a hex file.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  encoder can accept a beat.
- in_mnem  in  4  0 R, 1 ADDI, 2 ORI, 3 LUI, 4 BEQ, 5 BNE, 6 SW, 7 LW, 8 J, 9 JAL; 10-15 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type function code.
- in_imm  in  16  I-type immediate.
- in_target  in  26  J-type target.
- in_last  in  1  marks the final beat of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  write word address.
- mem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_WIDTH+1  words written this session.
- load_done  out  1  session finished; level output.
- full  out  1  capacity reached.
- err_illegal  out  1  sticky flag; illegal mnemonic seen.
- err_overflow  out  1  sticky flag; in_valid presented while full.

Behaviour:
- Reset: state IDLE. in_ready, mem_we, load_done, full, err_* all 0. mem_addr = BASE_ADDR. mem_wdata = 0. word_count = 0.
- FSM states: IDLE, LOAD, DONE, FULL.
  - IDLE/DONE/FULL + start: go to LOAD. Clear word_count, err_*, load_done and full. Set write pointer to BASE_ADDR.
  - start in LOAD is ignored.
- in_ready = 1 only in LOAD. A beat is accepted when in_valid && in_ready.
- Encoding is a registered stage. The accepted beat appears on mem_we/mem_addr/mem_wdata the next cycle; latency 1. Throughput is 1 word/cycle. mem_we is a single-cycle pulse per word.
- Word formats:
  - R: {6'h00, rs, rt, rd, shamt, funct}.
  - ADDI 0x08, ORI 0x0d, BEQ 0x04, BNE 0x05, SW 0x2b, LW 0x23: {op, rs, rt, imm}.
  - LUI 0x0f: {op, 5'd0, rt, imm}; in_rs is ignored.
  - J 0x02, JAL 0x03: {op, target}.
- Illegal mnemonic:
  - The beat is still accepted (consumed).
  - No write is issued and word_count/pointer do not advance. err_illegal is set.
  - If it carries in_last, the session still ends: DONE on the next cycle.
- After each write: pointer +1, wrapping modulo DEPTH, and word_count +1.
- Last beat: an accepted beat with in_last goes to DONE on the cycle its write issues. load_done = 1 while in DONE.
- Capacity: when the DEPTH-th word is accepted, in_ready drops the next cycle. After that write the state is FULL; full = 1 and load_done = 1. No further writes occur.
- in_valid while in FULL sets err_overflow; no beat is consumed.
- If in_last arrives on the DEPTH-th word, DONE and FULL coincide: state is FULL and load_done = 1.
- Reset mid-session: any pending registered write is discarded and mem_we = 0 on the next cycle. All outputs return to reset values.
- in_valid outside LOAD (except FULL) is ignored and raises no error.

Decomposition:
- Shared package mips_isa_pkg:
  - opcode localparams (0x00, 0x08, 0x0d, 0x0f, 0x04, 0x05, 0x2b, 0x23, 0x02, 0x03);
  - mnemonic enum codes;
  - field bit positions.
- The control decoder should also consume this package.
- One natural sub-module: instr_word_encoder, a combinational block from fields to 32-bit word plus an illegal flag. The top level holds the FSM, pointer, count and output register.

Test Plan:
- start; ADDI rs=0 rt=8 imm=0x0005 -> next cycle mem_we=1, mem_addr=0x00, mem_wdata=0x20080005, word_count=1.
- R rs=8 rt=9 rd=10 shamt=0 funct=0x20, then J target=0x0100008 with in_last -> writes 0x01095020 at 0x00 and 0x08100008 at 0x01; load_done=1, in_ready=0.
- LUI rs=7 rt=1 imm=0x1001 -> 0x3C011001, confirming rs is forced to 0.
- in_mnem=0xC between two valid ADDIs -> the two ADDIs land at 0x00 and 0x01 with no gap; err_illegal=1; word_count=2.
- ADDR_WIDTH=2, in_valid held for 6 beats -> 4 writes at 0-3, full=1, in_ready=0, err_overflow=1.
- reset asserted the cycle after a beat is accepted -> no mem_we pulse; all outputs at reset values; a following start restarts at BASE_ADDR.

Source files
------------

// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_isa_pkg
// Brief   : MIPS opcode, mnemonic and field-position definitions shared by
//           the instruction encoder/loader and the control decoder.
// Revision: 1.0 - initial release
// ============================================================================
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [3:0] {
    MN_R    = 4'd0,
    MN_ADDI = 4'd1,
    MN_ORI  = 4'd2,
    MN_LUI  = 4'd3,
    MN_BEQ  = 4'd4,
    MN_BNE  = 4'd5,
    MN_SW   = 4'd6,
    MN_LW   = 4'd7,
    MN_J    = 4'd8,
    MN_JAL  = 4'd9
  } mnem_e;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  function automatic logic [31:0] enc_i_type(input logic [5:0]  op,
                                             input logic [4:0]  rs,
                                             input logic [4:0]  rt,
                                             input logic [15:0] imm);
    logic [31:0] w;
    w = 32'd0;
    w[OP_MSB:OP_LSB]   = op;
    w[RS_MSB:RS_LSB]   = rs;
    w[RT_MSB:RT_LSB]   = rt;
    w[IMM_MSB:IMM_LSB] = imm;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_word_encoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_word_encoder
// Brief   : Combinational assembly of a 32-bit MIPS word from decoded fields,
//           flagging mnemonic codes outside the supported set.
// Revision: 1.0 - initial release
// ============================================================================
module instr_word_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = 32'd0;
    illegal_o = 1'b0;
    case (mnem_i)
      MN_R: begin
        word_o[OP_MSB:OP_LSB]       = OP_RTYPE;
        word_o[RS_MSB:RS_LSB]       = rs_i;
        word_o[RT_MSB:RT_LSB]       = rt_i;
        word_o[RD_MSB:RD_LSB]       = rd_i;
        word_o[SHAMT_MSB:SHAMT_LSB] = shamt_i;
        word_o[FUNCT_MSB:FUNCT_LSB] = funct_i;
      end
      MN_ADDI: word_o = enc_i_type(OP_ADDI, rs_i, rt_i, imm_i);
      MN_ORI:  word_o = enc_i_type(OP_ORI,  rs_i, rt_i, imm_i);
      // LUI has no source register; rs field is architecturally zero.
      MN_LUI:  word_o = enc_i_type(OP_LUI,  5'd0, rt_i, imm_i);
      MN_BEQ:  word_o = enc_i_type(OP_BEQ,  rs_i, rt_i, imm_i);
      MN_BNE:  word_o = enc_i_type(OP_BNE,  rs_i, rt_i, imm_i);
      MN_SW:   word_o = enc_i_type(OP_SW,   rs_i, rt_i, imm_i);
      MN_LW:   word_o = enc_i_type(OP_LW,   rs_i, rt_i, imm_i);
      MN_J: begin
        word_o[OP_MSB:OP_LSB]         = OP_J;
        word_o[TARGET_MSB:TARGET_LSB] = target_i;
      end
      MN_JAL: begin
        word_o[OP_MSB:OP_LSB]         = OP_JAL;
        word_o[TARGET_MSB:TARGET_LSB] = target_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module  : instr_encode_loader
// Brief   : Accepts instruction beats, encodes them and writes the words
//           sequentially into instruction memory with one cycle of latency.
// Revision: 1.0 - initial release
// ============================================================================
module instr_encode_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_mnem,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  load_done,
  output logic                  full,
  output logic                  err_illegal,
  output logic                  err_overflow
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_FULL = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_ill_q, err_ill_d;
  logic                  err_ovf_q, err_ovf_d;

  logic [31:0] enc_word;
  logic        enc_illegal;

  instr_word_encoder u_enc (
    .mnem_i   (in_mnem),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .funct_i  (in_funct),
    .imm_i    (in_imm),
    .target_i (in_target),
    .word_o   (enc_word),
    .illegal_o(enc_illegal)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_ill_d = err_ill_q;
    err_ovf_d = err_ovf_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (enc_illegal) begin
            err_ill_d = 1'b1;
            if (in_last) state_d = S_DONE;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
            // Capacity takes precedence so a last beat on the final slot reports FULL.
            if (count_q == LAST_CNT) state_d = S_FULL;
            else if (in_last)        state_d = S_DONE;
          end
        end
      end
      S_FULL: begin
        if (in_valid) err_ovf_d = 1'b1;
      end
      default: ;
    endcase

    if (start && (state_q != S_LOAD)) begin
      state_d   = S_LOAD;
      ptr_d     = BASE;
      addr_d    = BASE;
      count_d   = '0;
      err_ill_d = 1'b0;
      err_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= BASE;
      count_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= BASE;
      wdata_q   <= 32'd0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_ill_q <= err_ill_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign word_count   = count_q;
  assign load_done    = (state_q == S_DONE) || (state_q == S_FULL);
  assign full         = (state_q == S_FULL);
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_encode_loader
// Brief   : Directed self-checking bench for instr_encode_loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_mnem = 4'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
  logic [5:0]  in_funct = 6'd0;
  logic [15:0] in_imm = 16'd0;
  logic [25:0] in_target = 26'd0;
  logic        in_last = 1'b0;

  logic        in_ready, mem_we, load_done, full, err_illegal, err_overflow;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  logic        in_ready_s, mem_we_s, load_done_s, full_s, err_illegal_s, err_overflow_s;
  logic [1:0]  mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic [2:0]  word_count_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .load_done(load_done), .full(full), .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  instr_encode_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .word_count(word_count_s),
    .load_done(load_done_s), .full(full_s), .err_illegal(err_illegal_s), .err_overflow(err_overflow_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                          input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    in_mnem = mn; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %h want 00", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    n_checks++; if (word_count !== 9'd0) $display("FAIL reset_word_count: got %0d want 0", word_count); else n_pass++;
    n_checks++; if ({load_done, full, err_illegal, err_overflow} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {load_done, full, err_illegal, err_overflow}); else n_pass++;
  endtask

  task automatic test_addi();
    pulse_start();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL addi_ready: got %b want 1", in_ready); else n_pass++;
    set_beat(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1) $display("FAIL addi_we: got %b want 1", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 8'h00) $display("FAIL addi_addr: got %h want 00", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h20080005) $display("FAIL addi_wdata: got %h want 20080005", mem_wdata); else n_pass++;
    n_checks++; if (word_count !== 9'd1) $display("FAIL addi_count: got %0d want 1", word_count); else n_pass++;
    step();
    n_checks++; if (mem_we !== 1'b0) $display("FAIL addi_we_pulse: got %b want 0", mem_we); else n_pass++;
  endtask

  task automatic test_r_then_j();
    reset = 1'b1; step(); reset = 1'b0;
    pulse_start();
    set_beat(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'd0, 1'b0);
    in_valid = 1'b1;
    step();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h01095020)
      $display("FAIL r_write: got we=%b addr=%h data=%h want we=1 addr=00 data=01095020", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    set_beat(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0100008, 1'b1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 32'h08100008)
      $display("FAIL j_write: got we=%b addr=%h data=%h want we=1 addr=01 data=08100008", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++; if (load_done !== 1'b1 || in_ready !== 1'b0 || full !== 1'b0)
      $display("FAIL j_done: got done=%b ready=%b full=%b want 1 0 0", load_done, in_ready, full); else n_pass++;
    n_checks++; if (word_count !== 9'd2) $display("FAIL j_count: got %0d want 2", word_count); else n_pass++;
    step();
    n_checks++; if (mem_we !== 1'b0 || load_done !== 1'b1)
      $display("FAIL done_hold: got we=%b done=%b want 0 1", mem_we, load_done); else n_pass++;
  endtask

  task automatic test_lui();
    pulse_start();
    n_checks++; if (load_done !== 1'b0 || word_count !== 9'd0)
      $display("FAIL restart_clear: got done=%b count=%0d want 0 0", load_done, word_count); else n_pass++;
    set_beat(4'd3, 5'd7, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1001, 26'd0, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h3C011001)
      $display("FAIL lui_write: got we=%b addr=%h data=%h want we=1 addr=00 data=3c011001", mem_we, mem_addr, mem_wdata);
    else n_pass++;
  endtask

  task automatic test_formats();
    logic [3:0]  mn [6];
    logic [4:0]  rs [6];
    logic [4:0]  rt [6];
    logic [15:0] im [6];
    logic [25:0] tg [6];
    logic [31:0] ex [6];
    mn[0] = 4'd2; rs[0] = 5'd3;  rt[0] = 5'd4;  im[0] = 16'h00FF; tg[0] = 26'd0;         ex[0] = 32'h346400FF;
    mn[1] = 4'd4; rs[1] = 5'd0;  rt[1] = 5'd0;  im[1] = 16'hFFFE; tg[1] = 26'd0;         ex[1] = 32'h1000FFFE;
    mn[2] = 4'd5; rs[2] = 5'd1;  rt[2] = 5'd2;  im[2] = 16'hFFFF; tg[2] = 26'd0;         ex[2] = 32'h1422FFFF;
    mn[3] = 4'd6; rs[3] = 5'd29; rt[3] = 5'd31; im[3] = 16'h0010; tg[3] = 26'd0;         ex[3] = 32'hAFBF0010;
    mn[4] = 4'd7; rs[4] = 5'd8;  rt[4] = 5'd9;  im[4] = 16'h0004; tg[4] = 26'd0;         ex[4] = 32'h8D090004;
    mn[5] = 4'd9; rs[5] = 5'd0;  rt[5] = 5'd0;  im[5] = 16'h0000; tg[5] = 26'h3FFFFFF;   ex[5] = 32'h0FFFFFFF;
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_beat(mn[i], rs[i], rt[i], 5'd0, 5'd0, 6'd0, im[i], tg[i], (i == 5));
      step();
      n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'(i) || mem_wdata !== ex[i])
        $display("FAIL fmt%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                 i, mem_we, mem_addr, mem_wdata, 8'(i), ex[i]);
      else n_pass++;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_illegal();
    pulse_start();
    in_valid = 1'b1;
    set_beat(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b0);
    step();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h20220003)
      $display("FAIL ill_first: got we=%b addr=%h data=%h want we=1 addr=00 data=20220003", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    set_beat(4'hC, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b0);
    step();
    n_checks++; if (mem_we !== 1'b0 || err_illegal !== 1'b1 || word_count !== 9'd1)
      $display("FAIL ill_beat: got we=%b err=%b count=%0d want 0 1 1", mem_we, err_illegal, word_count); else n_pass++;
    set_beat(4'd1, 5'd1, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 32'h20230004)
      $display("FAIL ill_second: got we=%b addr=%h data=%h want we=1 addr=01 data=20230004", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++; if (word_count !== 9'd2 || err_illegal !== 1'b1 || load_done !== 1'b1)
      $display("FAIL ill_state: got count=%0d err=%b done=%b want 2 1 1", word_count, err_illegal, load_done); else n_pass++;
    // An illegal last beat still ends the session.
    pulse_start();
    n_checks++; if (err_illegal !== 1'b0) $display("FAIL ill_clear: got %b want 0", err_illegal); else n_pass++;
    set_beat(4'hF, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (mem_we !== 1'b0 || load_done !== 1'b1 || err_illegal !== 1'b1 || word_count !== 9'd0)
      $display("FAIL ill_last: got we=%b done=%b err=%b count=%0d want 0 1 1 0",
               mem_we, load_done, err_illegal, word_count); else n_pass++;
  endtask

  task automatic test_capacity();
    start_s = 1'b1; step(); start_s = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_beat(4'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
      step();
      if (i < 4) begin
        n_checks++; if (mem_we_s !== 1'b1 || mem_addr_s !== 2'(i) || mem_wdata_s !== (32'h20010000 | 32'(i)))
          $display("FAIL cap_write%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                   i, mem_we_s, mem_addr_s, mem_wdata_s, 2'(i), 32'h20010000 | 32'(i));
        else n_pass++;
      end else begin
        n_checks++; if (mem_we_s !== 1'b0) $display("FAIL cap_nowrite%0d: got %b want 0", i, mem_we_s); else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (full_s !== 1'b1 || in_ready_s !== 1'b0 || load_done_s !== 1'b1)
      $display("FAIL cap_full: got full=%b ready=%b done=%b want 1 0 1", full_s, in_ready_s, load_done_s); else n_pass++;
    n_checks++; if (err_overflow_s !== 1'b1 || word_count_s !== 3'd4)
      $display("FAIL cap_ovf: got ovf=%b count=%0d want 1 4", err_overflow_s, word_count_s); else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    in_valid = 1'b1;
    set_beat(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
    step(); step();
    n_checks++; if (mem_addr !== 8'h01 || word_count !== 9'd2)
      $display("FAIL mid_pre: got addr=%h count=%0d want 01 2", mem_addr, word_count); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0 || word_count !== 9'd0 || in_ready !== 1'b0)
      $display("FAIL mid_reset: got we=%b addr=%h data=%h count=%0d ready=%b want 0 00 0 0 0",
               mem_we, mem_addr, mem_wdata, word_count, in_ready); else n_pass++;
    step();
    n_checks++; if (mem_we !== 1'b0) $display("FAIL mid_no_we: got %b want 0", mem_we); else n_pass++;
    pulse_start();
    set_beat(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || word_count !== 9'd1 || load_done !== 1'b1)
      $display("FAIL mid_restart: got we=%b addr=%h count=%0d done=%b want 1 00 1 1",
               mem_we, mem_addr, word_count, load_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_r_then_j();
    test_lui();
    test_formats();
    test_illegal();
    test_capacity();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
